// File: rtl/track_mix_stage.sv
// Two-source gain/sum mixer for the i2s left channel, one mix per ws frame.
// Optional peak meter output enabled by defining TRACK_MIX_PEAK_EN.
module track_mix_stage #(
    parameter int WORD_WIDTH  = 8,
    parameter int GAIN_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ws,
    input  logic [WORD_WIDTH-1:0] live_in,
    input  logic [WORD_WIDTH-1:0] track_in,
    input  logic [GAIN_WIDTH-1:0] live_gain,
    input  logic [GAIN_WIDTH-1:0] track_gain,
    input  logic                  mute,
    input  logic                  clr_flags,
    output logic [WORD_WIDTH-1:0] mix_out,
    output logic                  mix_valid,
    output logic                  sat_flag,
    output logic                  overrun
`ifdef TRACK_MIX_PEAK_EN
    ,
    output logic [WORD_WIDTH-2:0] peak_level
`endif
);

    localparam int W    = WORD_WIDTH;
    localparam int G    = GAIN_WIDTH;
    localparam int PW   = W + G + 1;
    localparam int SW   = W + G + 2;
    localparam int FRAC = 3;

    localparam logic signed [SW-1:0] MAX_V = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CAPTURE, MULT, SUM} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] ws_sync;
    logic                   ws_hist;
    logic                   frame_edge;

    logic [W-1:0] live_q, track_q;
    logic [G-1:0] live_gain_q, track_gain_q;
    logic         mute_q;

    logic signed [PW-1:0] live_ext, track_ext, lgain_ext, tgain_ext;
    logic signed [PW-1:0] prod_l, prod_t;
    logic signed [PW-1:0] p_l, p_t;
    logic signed [SW-1:0] sum, shifted;
    logic [W-1:0]         mix_nx;
    logic                 clip;
    logic                 sat_set, ovr_set;

    assign frame_edge = ws_hist & ~ws_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_sync <= '0;
            ws_hist <= 1'b0;
        end else begin
            ws_sync <= {ws_sync[SYNC_STAGES-2:0], ws};
            ws_hist <= ws_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (frame_edge) state_nx = CAPTURE;
            CAPTURE: state_nx = MULT;
            MULT:    state_nx = SUM;
            SUM:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Gains are unsigned, so they are zero-extended before the signed multiply.
    always_comb begin
        live_ext  = {{(G+1){live_q[W-1]}}, live_q};
        track_ext = {{(G+1){track_q[W-1]}}, track_q};
        lgain_ext = {{(W+1){1'b0}}, live_gain_q};
        tgain_ext = {{(W+1){1'b0}}, track_gain_q};
        prod_l    = live_ext * lgain_ext;
        prod_t    = track_ext * tgain_ext;
    end

    always_comb begin
        sum     = {p_l[PW-1], p_l} + {p_t[PW-1], p_t};
        shifted = sum >>> FRAC;
        clip    = 1'b0;
        mix_nx  = shifted[W-1:0];
        if (mute_q) begin
            mix_nx = '0;
        end else if (shifted > MAX_V) begin
            mix_nx = {1'b0, {(W-1){1'b1}}};
            clip   = 1'b1;
        end else if (shifted < MIN_V) begin
            mix_nx = {1'b1, {(W-1){1'b0}}};
            clip   = 1'b1;
        end
    end

    assign sat_set = (state == MULT) & clip;
    assign ovr_set = frame_edge & (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q       <= '0;
            track_q      <= '0;
            live_gain_q  <= '0;
            track_gain_q <= '0;
            mute_q       <= 1'b0;
            p_l          <= '0;
            p_t          <= '0;
        end else begin
            if (state == IDLE && frame_edge) begin
                live_q       <= live_in;
                track_q      <= track_in;
                live_gain_q  <= live_gain;
                track_gain_q <= track_gain;
                mute_q       <= mute;
            end
            if (state == CAPTURE) begin
                p_l <= prod_l;
                p_t <= prod_t;
            end
        end
    end

    // mix_valid is a one-cycle strobe with no back-pressure: mix_out changes only
    // in the cycle mix_valid is high and holds until the next strobe. The result
    // is written on the MULT->SUM edge so it is visible during SUM, 3 cycles
    // after the frame edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_out   <= '0;
            mix_valid <= 1'b0;
            sat_flag  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= (state == MULT);
            if (state == MULT) mix_out <= mix_nx;
            sat_flag <= sat_set | (sat_flag & ~clr_flags);
            overrun  <= ovr_set | (overrun & ~clr_flags);
        end
    end

`ifdef TRACK_MIX_PEAK_EN
    logic [19:0]  decay_cnt;
    logic [W-1:0] neg_mix;
    logic [W-2:0] mag;

    // The most negative sample has no positive twin, so it maps to full scale.
    always_comb begin
        neg_mix = -mix_out;
        if (!mix_out[W-1])                      mag = mix_out[W-2:0];
        else if (mix_out == {1'b1, {(W-1){1'b0}}}) mag = {(W-1){1'b1}};
        else                                    mag = neg_mix[W-2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decay_cnt  <= '0;
            peak_level <= '0;
        end else begin
            decay_cnt <= decay_cnt + 20'd1;
            if (mix_valid && mag > peak_level)
                peak_level <= mag;
            else if (decay_cnt == 20'hFFFFF && peak_level != '0)
                peak_level <= peak_level - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_track_mix_stage.sv
// Directed bench for track_mix_stage: arithmetic frame model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_track_mix_stage;

    localparam int W = 8;
    localparam int G = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ws;
    logic [W-1:0] live_in, track_in;
    logic [G-1:0] live_gain, track_gain;
    logic         mute, clr_flags;
    logic [W-1:0] mix_out;
    logic         mix_valid, sat_flag, overrun;
`ifdef TRACK_MIX_PEAK_EN
    logic [W-2:0] peak_level;
`endif

    always #5 clk = ~clk;

    track_mix_stage #(.WORD_WIDTH(W), .GAIN_WIDTH(G), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ws         (ws),
        .live_in    (live_in),
        .track_in   (track_in),
        .live_gain  (live_gain),
        .track_gain (track_gain),
        .mute       (mute),
        .clr_flags  (clr_flags),
        .mix_out    (mix_out),
        .mix_valid  (mix_valid),
        .sat_flag   (sat_flag),
        .overrun    (overrun)
`ifdef TRACK_MIX_PEAK_EN
        ,
        .peak_level (peak_level)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame model: a ws fall driven after posedge n is seen as a frame edge at
    // cycle n+S; if accepted, the mix appears 3 cycles later.
    typedef struct {
        int due;
        int val;
        int sat;
    } pend_t;

    int    fe_q[$];
    pend_t pend_q[$];
    int    m_out, m_valid, m_sat, m_ovr, last_due;
    int    vcount = 0;

    function automatic void mix_model(input int l, input int t, input int lg, input int tg,
                                      input int m, output int val, output int sat);
        int s;
        int r;
        val = 0;
        sat = 0;
        if (m == 0) begin
            s = l * lg + t * tg;
            r = s >>> 3;
            if (r > 127) begin
                val = 127;
                sat = 1;
            end else if (r < -128) begin
                val = -128;
                sat = 1;
            end else begin
                val = r;
            end
        end
    endfunction

    always @(negedge clk) begin
        int n_valid, sat_set, ovr_set, v, s;
        if (!rst_n) begin
            chk("rst_mix_out", int'($signed(mix_out)), 0);
            chk("rst_mix_valid", int'(mix_valid), 0);
            chk("rst_sat_flag", int'(sat_flag), 0);
            chk("rst_overrun", int'(overrun), 0);
            m_out = 0; m_valid = 0; m_sat = 0; m_ovr = 0; last_due = -100;
            fe_q.delete();
            pend_q.delete();
        end else begin
            chk("mix_out", int'($signed(mix_out)), m_out);
            chk("mix_valid", int'(mix_valid), m_valid);
            chk("sat_flag", int'(sat_flag), m_sat);
            chk("overrun", int'(overrun), m_ovr);
            if (mix_valid) vcount++;
            n_valid = 0; sat_set = 0; ovr_set = 0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc + 1) begin
                m_out   = pend_q[0].val;
                n_valid = 1;
                sat_set = pend_q[0].sat;
                void'(pend_q.pop_front());
            end
            if (fe_q.size() > 0 && fe_q[0] == cyc) begin
                void'(fe_q.pop_front());
                if (cyc > last_due) begin
                    mix_model(int'($signed(live_in)), int'($signed(track_in)), int'(live_gain),
                              int'(track_gain), int'(mute), v, s);
                    pend_q.push_back('{due: cyc + 3, val: v, sat: s});
                    last_due = cyc + 3;
                end else begin
                    ovr_set = 1;
                end
            end
            m_valid = n_valid;
            m_sat = sat_set ? 1 : (clr_flags ? 0 : m_sat);
            m_ovr = ovr_set ? 1 : (clr_flags ? 0 : m_ovr);
        end
    end

    task automatic set_inputs(input int l, input int t, input int lg, input int tg, input int m);
        live_in    = W'(l);
        track_in   = W'(t);
        live_gain  = G'(lg);
        track_gain = G'(tg);
        mute       = (m != 0);
    endtask

    task automatic drop_ws(output int n);
        @(posedge clk); #1;
        ws = 1'b0;
        n = cyc;
        fe_q.push_back(cyc + S);
    endtask

    task automatic send_frame(input int l, input int t, input int lg, input int tg,
                              input int m, output int n);
        @(posedge clk); #1;
        set_inputs(l, t, lg, tg, m);
        ws = 1'b1;
        repeat (2) @(posedge clk);
        drop_ws(n);
    endtask

    task automatic wait_valid(input int n, output int lat);
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mix_valid) begin
                lat = cyc - n;
                break;
            end
        end
        if (lat < 0) chk("valid_timeout", 0, 1);
    endtask

    task automatic frame_check(input string name, input int l, input int t, input int lg,
                               input int tg, input int m, input int exp_mix, input int exp_sat);
        int n, lat;
        send_frame(l, t, lg, tg, m, n);
        wait_valid(n, lat);
        chk({name, "_latency"}, lat, S + 3);
        chk({name, "_mix"}, int'($signed(mix_out)), exp_mix);
        chk({name, "_sat"}, int'(sat_flag), exp_sat);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_flags = 1'b1;
        @(posedge clk); #1 clr_flags = 1'b0;
        chk("clr_sat", int'(sat_flag), 0);
        chk("clr_ovr", int'(overrun), 0);
    endtask

    initial begin
        int n, vc0;
        rst_n = 1'b0; ws = 1'b0; clr_flags = 1'b0;
        set_inputs(0, 0, 0, 0, 0);
        repeat (6) begin
            @(posedge clk); #1;
            set_inputs($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 1));
            ws        = 1'($urandom_range(0, 1));
            clr_flags = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        ws = 1'b1; clr_flags = 1'b0;
        chk("reset_hold_mix", int'(mix_out), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        frame_check("unity", 20, -5, 8, 8, 0, 15, 0);
        frame_check("pos_sat", 100, 100, 8, 8, 0, 127, 1);
        repeat (6) @(posedge clk);
        #1 chk("sat_sticky", int'(sat_flag), 1);
        frame_check("neg_sat", -128, 0, 15, 8, 0, -128, 1);
        frame_check("gain4", -64, 0, 4, 8, 0, -32, 1);
        pulse_clr();
        frame_check("gains_zero", 50, -70, 0, 0, 0, 0, 0);
        frame_check("live_gain_zero", 37, -90, 0, 8, 0, -90, 0);
        frame_check("floor_shift", -5, 3, 1, 1, 0, -1, 0);
        frame_check("mute", 100, 100, 15, 15, 1, 0, 0);

        // Inputs move after the frame; mix_out must hold.
        @(posedge clk); #1;
        set_inputs(-77, 55, 15, 15, 0);
        repeat (8) @(posedge clk);
        #1 chk("hold_mix", int'($signed(mix_out)), 0);

        // clr_flags lands on the same edge as a saturating result: set wins.
        chk("pre_setwins_sat", int'(sat_flag), 0);
        send_frame(127, 127, 15, 15, 0, n);
        repeat (4) @(posedge clk);
        #1 clr_flags = 1'b1;
        @(posedge clk); #1 clr_flags = 1'b0;
        chk("setwins_valid", int'(mix_valid), 1);
        chk("setwins_mix", int'($signed(mix_out)), 127);
        chk("setwins_sat", int'(sat_flag), 1);
        pulse_clr();

        // Second falling edge two cycles after the first is dropped.
        chk("pre_ovr", int'(overrun), 0);
        @(posedge clk); #1;
        set_inputs(10, 6, 8, 8, 0);
        ws = 1'b1;
        repeat (2) @(posedge clk);
        drop_ws(n);
        @(posedge clk); #1 ws = 1'b1;
        vc0 = vcount;
        drop_ws(n);
        repeat (15) @(posedge clk);
        #1;
        chk("ovr_pulses", vcount - vc0, 1);
        chk("ovr_flag", int'(overrun), 1);
        chk("ovr_mix", int'($signed(mix_out)), 16);
        pulse_clr();

        // Reset during MULT aborts the frame.
        send_frame(40, 40, 8, 8, 0, n);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        vc0 = vcount;
        #1;
        chk("abort_mix", int'(mix_out), 0);
        chk("abort_valid", int'(mix_valid), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_pulses", vcount - vc0, 0);
        chk("abort_mix_after", int'(mix_out), 0);

        frame_check("recover", 20, -5, 8, 8, 0, 15, 0);
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        chk("watchdog", 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/track_mix_stage.md
Name: track_mix_stage

Overview:
- Sits between the track store/load block and the i2s transmitter's left-channel input, in the 100 MHz domain.
- Once per i2s frame it captures the live received sample and the stored playback sample.
- It applies a per-source gain, sums the two with saturation, and holds the result stable for the transmitter.
- It replaces the switch-driven mux in front of the transmitter, so live monitoring and overdub playback can be heard simultaneously.

Parameters:
- WORD_WIDTH, 8, signed two's-complement sample width.
- GAIN_WIDTH, 4, unsigned gain width. Gain is Q1.3: value 8 = unity, 15 = 1.875x.
- SYNC_STAGES, 2, flip-flop depth of the ws synchronizer (minimum 2).

Ports:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ws  in  1  transmitter word-select (lrclk), asynchronous to clk.
- live_in  in  WORD_WIDTH  signed live sample from the i2s receiver.
- track_in  in  WORD_WIDTH  signed playback sample from track store/load.
- live_gain  in  GAIN_WIDTH  live gain (Q1.3).
- track_gain  in  GAIN_WIDTH  playback gain (Q1.3).
- mute  in  1  forces the mix to 0 at the next frame.
- mix_out  out  WORD_WIDTH  signed mixed sample; held between frames.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- sat_flag  out  1  sticky; set when any frame saturated.
- overrun  out  1  sticky; set when a frame edge arrived while busy.
- clr_flags  in  1  synchronous clear of sat_flag and overrun.

Behaviour:
- Reset state (asynchronous, rst_n=0): all outputs 0, FSM=IDLE, synchronizer flops 0, internal registers 0.
- ws synchronizer:
  - ws passes through SYNC_STAGES flops, then one more history flop.
  - frame_edge = synced ws falling (1 then 0). It is a one-cycle pulse.
- FSM states: IDLE -> CAPTURE -> MULT -> SUM -> IDLE.
  - IDLE: on frame_edge, register live_in, track_in, live_gain, track_gain and mute; go to CAPTURE. Call this cycle C0.
  - CAPTURE (C1): compute p_l = live * live_gain and p_t = track * track_gain. Each product is signed, width WORD_WIDTH+GAIN_WIDTH+1; gain is zero-extended. Register both.
  - MULT (C2): s = p_l + p_t, width WORD_WIDTH+GAIN_WIDTH+2. Arithmetic shift right by 3 to get r.
  - SUM (C3): saturate r to [-2^(W-1), 2^(W-1)-1].
    - If mute was captured, the result is 0 and no saturation is flagged.
    - Register mix_out, pulse mix_valid for exactly this cycle, set sat_flag if clipped. Return to IDLE.
- Latency: mix_out and mix_valid become valid 3 cycles after the frame_edge cycle.
- Boundary conditions:
  - frame_edge while not IDLE: sample dropped, overrun set, FSM unaffected.
  - clr_flags and a new set event in the same cycle: set wins.
  - Gain 0: that source contributes 0.
  - Both gains 0: output 0, mix_valid still pulses.
  - Inputs may change at any time; only values captured at C0 are used.
  - rst_n asserted mid-sequence: immediate return to IDLE with all outputs 0. No mix_valid pulse for the aborted frame.
  - ws rising edges are ignored.

Optional Feature:
- Macro: TRACK_MIX_PEAK_EN.
- When defined:
  - Adds output peak_level [WORD_WIDTH-2:0].
  - On each mix_valid, peak_level takes |mix_out| (with -2^(W-1) mapped to 2^(W-1)-1) if that exceeds the held value.
  - Otherwise a 20-bit decay counter decrements peak_level by 1 every 2^20 clk cycles, floored at 0.
  - peak_level resets to 0. Intended to drive LEDs.
- When undefined: no port, no logic, and identical behaviour on all other ports.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, toggle ws -> first mix_valid exactly 3 cycles after the synced falling edge.
- Unity mix: live=20, track=-5, gains 8/8 -> mix_out=15, sat_flag=0.
- Positive saturation: live=100, track=100, gains 8/8 -> mix_out=127, sat_flag=1; the flag stays 1 until clr_flags pulses.
- Negative saturation and gain: live=-128, track=0, live_gain=15 -> mix_out=-128, sat_flag=1. Then live=-64, live_gain=4 -> mix_out=-32.
- Mute and hold: mute=1 with live=50 -> mix_out=0, no sat. Change live_in between frames -> mix_out unchanged until the next mix_valid.
- Overrun and reset abort: second ws falling edge 2 cycles after the first -> overrun=1 and one mix_valid only. Assert rst_n=0 at C2 -> no mix_valid, outputs 0.
